// File: rtl/pkt_comm_pkg.sv
// Shared packet-comm definitions: header layout, parser state encoding and default limits.
// The CSUM state exists only when INPKT_CHECKSUM_EN is defined.
package pkt_comm;

    localparam int unsigned DEFAULT_VERSION = 2;
    localparam int unsigned DEFAULT_MAX_LEN = 65536;

    localparam int unsigned HDR_BYTES = 10;
    localparam logic [3:0]  HDR_LAST  = 4'(HDR_BYTES - 1);
    localparam logic [3:0]  CSUM_LAST = 4'd3;

    // Byte offsets within the header; offsets 2, 3 and 7 are reserved
    localparam logic [3:0] OFF_VERSION = 4'd0;
    localparam logic [3:0] OFF_TYPE    = 4'd1;
    localparam logic [3:0] OFF_LEN0    = 4'd4;
    localparam logic [3:0] OFF_LEN1    = 4'd5;
    localparam logic [3:0] OFF_LEN2    = 4'd6;
    localparam logic [3:0] OFF_ID0     = 4'd8;
    localparam logic [3:0] OFF_ID1     = 4'd9;

`ifdef INPKT_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CSUM    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_ERROR   = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/inpkt_out_reg.sv
// Single-entry output register for the payload stream: holds while stalled,
// reloads in the same cycle as a transfer so full throughput has no bubble.
module inpkt_out_reg (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_end,
    input  logic       take,
    input  logic       clear,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_end
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       end_q, end_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        end_d   = end_q;
        if (valid_q && take) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            end_d   = load_end;
        end
        if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    assign dout       = data_q;
    assign dout_valid = valid_q;
    assign dout_end   = end_q;

endmodule

// File: rtl/inpkt_hdr_parser.sv
// Inbound packet parser: strips the 10-byte header from a FWFT byte FIFO and streams the payload.
// Define INPKT_CHECKSUM_EN to verify a trailing 4-byte inverted-sum checksum per packet.
module inpkt_hdr_parser
    import pkt_comm::*;
#(
    parameter int unsigned PKT_COMM_VERSION = DEFAULT_VERSION,
    parameter int unsigned PKT_MAX_LEN      = DEFAULT_MAX_LEN
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  din,
    input  logic        empty,
    output logic        rd_en,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_rd_en,
    output logic [7:0]  pkt_type,
    output logic [15:0] pkt_id,
    output logic [23:0] pkt_len,
    output logic        pkt_new,
    output logic        pkt_end,
    output logic        err_version,
    output logic        err_len,
    output logic        err_checksum
);

    localparam logic [7:0] VER_BYTE = 8'(PKT_COMM_VERSION);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  ver_q, ver_d;
    logic [7:0]  type_q, type_d;
    logic [23:0] len_q, len_d;
    logic [7:0]  id_lo_q, id_lo_d;
    logic [23:0] remain_q, remain_d;
    logic [7:0]  pkt_type_q, pkt_type_d;
    logic [15:0] pkt_id_q, pkt_id_d;
    logic [23:0] pkt_len_q, pkt_len_d;
    logic        pkt_new_q, pkt_new_d;
    logic        err_version_q, err_version_d;
    logic        err_len_q, err_len_d;
    logic        bad_ver, bad_len;
    logic        out_load, out_end, out_clear, dout_end;
`ifdef INPKT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic [23:0] csum_q, csum_d;
    logic        err_checksum_q, err_checksum_d;
`endif

    // Gated by reset so nothing is pulled from the FIFO while held in reset
    always_comb begin
        rd_en = 1'b0;
        if (RST_N) begin
            case (state_q)
                ST_HDR:     rd_en = !empty;
                ST_PAYLOAD: rd_en = !empty && (!dout_valid || dout_rd_en);
`ifdef INPKT_CHECKSUM_EN
                ST_CSUM:    rd_en = !empty;
`endif
                default:    rd_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ver_d         = ver_q;
        type_d        = type_q;
        len_d         = len_q;
        id_lo_d       = id_lo_q;
        remain_d      = remain_q;
        pkt_type_d    = pkt_type_q;
        pkt_id_d      = pkt_id_q;
        pkt_len_d     = pkt_len_q;
        pkt_new_d     = 1'b0;
        err_version_d = err_version_q;
        err_len_d     = err_len_q;
        bad_ver       = 1'b0;
        bad_len       = 1'b0;
        out_load      = 1'b0;
        out_end       = 1'b0;
        out_clear     = 1'b0;
`ifdef INPKT_CHECKSUM_EN
        sum_d          = sum_q;
        csum_d         = csum_q;
        err_checksum_d = err_checksum_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (rd_en) begin
                    case (cnt_q)
                        OFF_VERSION: ver_d          = din;
                        OFF_TYPE:    type_d         = din;
                        OFF_LEN0:    len_d[7:0]     = din;
                        OFF_LEN1:    len_d[15:8]    = din;
                        OFF_LEN2:    len_d[23:16]   = din;
                        OFF_ID0:     id_lo_d        = din;
                        default:     ;
                    endcase
`ifdef INPKT_CHECKSUM_EN
                    sum_d = (cnt_q == '0) ? 32'(din) : sum_q + 32'(din);
`endif
                    if (cnt_q == HDR_LAST) begin
                        cnt_d   = '0;
                        bad_ver = (ver_q != VER_BYTE);
                        bad_len = (len_q == '0) || (32'(len_q) > PKT_MAX_LEN);
                        if (bad_ver || bad_len) begin
                            err_version_d = err_version_q | bad_ver;
                            err_len_d     = err_len_q | bad_len;
                            out_clear     = 1'b1;
                            state_d       = ST_ERROR;
                        end else begin
                            // id high byte is the byte on din right now
                            pkt_new_d  = 1'b1;
                            pkt_type_d = type_q;
                            pkt_id_d   = {din, id_lo_q};
                            pkt_len_d  = len_q;
                            remain_d   = len_q;
                            state_d    = ST_PAYLOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_en) begin
                    out_load = 1'b1;
                    out_end  = (remain_q == 24'd1);
                    remain_d = remain_q - 24'd1;
`ifdef INPKT_CHECKSUM_EN
                    sum_d = sum_q + 32'(din);
                    if (remain_q == 24'd1) state_d = ST_CSUM;
`else
                    if (remain_q == 24'd1) state_d = ST_HDR;
`endif
                end
            end
`ifdef INPKT_CHECKSUM_EN
            ST_CSUM: begin
                if (rd_en) begin
                    case (cnt_q[1:0])
                        2'd0:    csum_d[7:0]   = din;
                        2'd1:    csum_d[15:8]  = din;
                        2'd2:    csum_d[23:16] = din;
                        default: ;
                    endcase
                    if (cnt_q == CSUM_LAST) begin
                        cnt_d = '0;
                        if ({din, csum_q} == ~sum_q) begin
                            state_d = ST_HDR;
                        end else begin
                            err_checksum_d = 1'b1;
                            out_clear      = 1'b1;
                            state_d        = ST_ERROR;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_HDR;
            cnt_q         <= '0;
            ver_q         <= '0;
            type_q        <= '0;
            len_q         <= '0;
            id_lo_q       <= '0;
            remain_q      <= '0;
            pkt_type_q    <= '0;
            pkt_id_q      <= '0;
            pkt_len_q     <= '0;
            pkt_new_q     <= 1'b0;
            err_version_q <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ver_q         <= ver_d;
            type_q        <= type_d;
            len_q         <= len_d;
            id_lo_q       <= id_lo_d;
            remain_q      <= remain_d;
            pkt_type_q    <= pkt_type_d;
            pkt_id_q      <= pkt_id_d;
            pkt_len_q     <= pkt_len_d;
            pkt_new_q     <= pkt_new_d;
            err_version_q <= err_version_d;
            err_len_q     <= err_len_d;
        end
    end

`ifdef INPKT_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q          <= '0;
            csum_q         <= '0;
            err_checksum_q <= 1'b0;
        end else begin
            sum_q          <= sum_d;
            csum_q         <= csum_d;
            err_checksum_q <= err_checksum_d;
        end
    end
    assign err_checksum = err_checksum_q;
`else
    assign err_checksum = 1'b0;
`endif

    inpkt_out_reg u_out_reg (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load       (out_load),
        .load_data  (din),
        .load_end   (out_end),
        .take       (dout_rd_en),
        .clear      (out_clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_end   (dout_end)
    );

    assign pkt_end     = dout_valid & dout_end;
    assign pkt_type    = pkt_type_q;
    assign pkt_id      = pkt_id_q;
    assign pkt_len     = pkt_len_q;
    assign pkt_new     = pkt_new_q;
    assign err_version = err_version_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_inpkt_hdr_parser.sv
// Bench for inpkt_hdr_parser: a tagged byte-stream model of the input FIFO predicts every output each cycle.
// Honours INPKT_CHECKSUM_EN when the design is built with it.
module tb_inpkt_hdr_parser;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  din = '0;
    logic        empty = 1'b1;
    logic        rd_en;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_rd_en = 1'b0;
    logic [7:0]  pkt_type;
    logic [15:0] pkt_id;
    logic [23:0] pkt_len;
    logic        pkt_new, pkt_end;
    logic        err_version, err_len, err_checksum;

    always #5 CLK = ~CLK;

    inpkt_hdr_parser #(.PKT_COMM_VERSION(2), .PKT_MAX_LEN(65536)) dut (
        .CLK(CLK), .RST_N(RST_N), .din(din), .empty(empty), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .dout_rd_en(dout_rd_en),
        .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_new(pkt_new), .pkt_end(pkt_end),
        .err_version(err_version), .err_len(err_len), .err_checksum(err_checksum)
    );

    localparam int K_HDR = 0, K_PAY = 1, K_CSUM = 2;

    typedef struct {
        logic [7:0]  data;
        int          kind;
        bit          last;
        bit          bad_ver;
        bit          bad_len;
        bit          bad_csum;
        logic [7:0]  typ;
        logic [15:0] id;
        logic [23:0] len;
    } ent_t;

    ent_t fifo[$];
    int   n_vec = 0, n_err = 0;
    int   stall_pct = 0, rd_mode = 0;
    bit   rsv_rand = 1'b0;

    // monitor / model state
    int          mcyc = 0, new_seen = 0;
    logic [8:0]  xfer_q[$];
    int          xfer_cyc[$];
    bit          prev_pop, prev_valid, prev_take, prev_e, errored, fatal_pop;
    logic [7:0]  prev_d;
    ent_t        prev_ent;
    bit          exp_dv, exp_e, exp_new, exp_rd;
    logic [7:0]  exp_d, exp_type;
    logic [15:0] exp_id;
    logic [23:0] exp_len;
    bit          exp_ev, exp_el, exp_ec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_packet(input logic [7:0] ver, input logic [7:0] typ, input logic [15:0] id,
                               input logic [23:0] len, input logic [7:0] pay[$], input bit corrupt);
        logic [7:0]  h[10];
        logic [31:0] s;
        ent_t        e;
        bit          bv, bl;
        bv = (ver != 8'd2);
        bl = (len == 24'd0) || (32'(len) > 32'd65536);
        h[0] = ver; h[1] = typ;
        h[2] = rsv_rand ? 8'($urandom) : 8'h00;
        h[3] = rsv_rand ? 8'($urandom) : 8'h00;
        h[4] = len[7:0]; h[5] = len[15:8]; h[6] = len[23:16];
        h[7] = rsv_rand ? 8'($urandom) : 8'h00;
        h[8] = id[7:0]; h[9] = id[15:8];
        s = 32'd0;
        for (int i = 0; i < 10; i++) begin
            e = '{data: h[i], kind: K_HDR, last: (i == 9), bad_ver: (i == 9) && bv,
                  bad_len: (i == 9) && bl, bad_csum: 1'b0, typ: typ, id: id, len: len};
            fifo.push_back(e);
            s = s + 32'(h[i]);
        end
        if (bv || bl) return;
        for (int j = 0; j < pay.size(); j++) begin
            e = '{data: pay[j], kind: K_PAY, last: (j == int'(len) - 1), bad_ver: 1'b0,
                  bad_len: 1'b0, bad_csum: 1'b0, typ: typ, id: id, len: len};
            fifo.push_back(e);
            s = s + 32'(pay[j]);
        end
`ifdef INPKT_CHECKSUM_EN
        if (pay.size() == int'(len)) begin
            logic [31:0] c;
            c = ~s;
            if (corrupt) c[0] = ~c[0];
            for (int k = 0; k < 4; k++) begin
                e = '{data: c[8*k +: 8], kind: K_CSUM, last: (k == 3), bad_ver: 1'b0,
                      bad_len: 1'b0, bad_csum: (k == 3) && corrupt, typ: typ, id: id, len: len};
                fifo.push_back(e);
            end
        end
`else
        if (corrupt) s = ~s;
`endif
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        empty = (fifo.size() == 0) || (int'($urandom_range(99)) < stall_pct);
        din   = (fifo.size() != 0 && !empty) ? fifo[0].data : 8'($urandom);
        case (rd_mode)
            0:       dout_rd_en = 1'b1;
            1:       dout_rd_en = !dout_rd_en;
            default: dout_rd_en = (int'($urandom_range(99)) < 70);
        endcase
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((fifo.size() != 0 || dout_valid) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_bound", (n < max), 1);
        run(2);
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        fifo.delete();
        empty = 1'b1;
        run(n);
        RST_N = 1'b1;
    endtask

    task automatic clear_log();
        new_seen = 0;
        xfer_q.delete();
        xfer_cyc.delete();
    endtask

    task automatic check_abc(input string tag, input bit consec);
        logic [8:0] ex;
        chk({tag, "_new_count"}, new_seen, 1);
        chk({tag, "_type"}, pkt_type, 8'h07);
        chk({tag, "_id"}, pkt_id, 16'h1234);
        chk({tag, "_len"}, pkt_len, 24'd3);
        chk({tag, "_xfer_count"}, xfer_q.size(), 3);
        for (int i = 0; i < xfer_q.size() && i < 3; i++) begin
            ex = {1'(i == 2), 8'(32'h61 + i)};
            chk({tag, "_byte"}, xfer_q[i], ex);
            if (consec) chk({tag, "_consecutive"}, xfer_cyc[i] - xfer_cyc[0], i);
        end
    endtask

    // Compare process: predicts each output from what was popped off the tagged stream
    always @(negedge CLK) begin
        mcyc++;
        if (!RST_N) begin
            chk("rst_flags", {rd_en, dout_valid, pkt_new, pkt_end, err_version, err_len, err_checksum}, 0);
            chk("rst_fields", {dout, pkt_type, pkt_id, pkt_len}, 0);
            prev_pop = 0; prev_valid = 0; prev_take = 0; prev_e = 0; prev_d = '0;
            errored = 0; exp_ev = 0; exp_el = 0; exp_ec = 0;
            exp_type = '0; exp_id = '0; exp_len = '0;
        end else begin
            fatal_pop = prev_pop && prev_ent.last && (prev_ent.bad_ver || prev_ent.bad_len || prev_ent.bad_csum);
            exp_dv = 0; exp_d = '0; exp_e = 0;
            if (prev_pop && prev_ent.kind == K_PAY) begin
                exp_dv = 1; exp_d = prev_ent.data; exp_e = prev_ent.last;
            end else if (prev_valid && !prev_take && !fatal_pop && !errored) begin
                exp_dv = 1; exp_d = prev_d; exp_e = prev_e;
            end
            chk("dout_valid", dout_valid, exp_dv);
            if (exp_dv) begin
                chk("dout", dout, exp_d);
                chk("pkt_end", pkt_end, exp_e);
            end else begin
                chk("pkt_end_idle", pkt_end, 0);
            end
            exp_new = prev_pop && prev_ent.kind == K_HDR && prev_ent.last && !prev_ent.bad_ver && !prev_ent.bad_len;
            chk("pkt_new", pkt_new, exp_new);
            if (exp_new) begin
                exp_type = prev_ent.typ; exp_id = prev_ent.id; exp_len = prev_ent.len;
            end
            if (pkt_new === 1'b1) new_seen++;
            chk("pkt_fields", {pkt_type, pkt_id, pkt_len}, {exp_type, exp_id, exp_len});
            if (prev_pop && prev_ent.last) begin
                exp_ev = exp_ev | prev_ent.bad_ver;
                exp_el = exp_el | prev_ent.bad_len;
                exp_ec = exp_ec | prev_ent.bad_csum;
            end
            errored = errored || fatal_pop;
            chk("err_flags", {err_version, err_len, err_checksum}, {exp_ev, exp_el, exp_ec});
            exp_rd = 0;
            if (!errored && !empty && fifo.size() != 0)
                exp_rd = (fifo[0].kind == K_PAY) ? (!dout_valid || dout_rd_en) : 1'b1;
            chk("rd_en", rd_en, exp_rd);
            if (dout_valid && dout_rd_en) begin
                xfer_q.push_back({pkt_end, dout});
                xfer_cyc.push_back(mcyc);
            end
            prev_valid = dout_valid; prev_d = dout; prev_e = pkt_end;
            prev_take  = dout_valid && dout_rd_en;
            prev_pop   = rd_en && !empty && fifo.size() != 0;
            if (prev_pop) prev_ent = fifo.pop_front();
        end
    end

    initial begin
        logic [7:0] abc[$];
        logic [7:0] p[$];
        abc = '{8'h61, 8'h62, 8'h63};

        run(3);
        RST_N = 1'b1;

        // Reference packet, sink always ready
        rd_mode = 0; stall_pct = 0; rsv_rand = 0;
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        drain(200);
        check_abc("t1", 1);

        // Same packet, sink toggling ready
        rd_mode = 1;
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        drain(200);
        check_abc("t2", 0);

        // Random traffic: stalled round then back-to-back full-throughput round
        for (int r = 0; r < 2; r++) begin
            rd_mode = (r == 0) ? 2 : 0;
            stall_pct = (r == 0) ? 25 : 0;
            rsv_rand = 1;
            clear_log();
            for (int k = 0; k < 20; k++) begin
                p.delete();
                repeat ($urandom_range(1, 24)) p.push_back(8'($urandom));
                push_packet(8'h02, 8'($urandom), 16'($urandom), 24'(p.size()), p, 0);
            end
            drain(8000);
            chk("rand_new_count", new_seen, 20);
        end

        // Maximum length accepted, then reset after 2 payload bytes
        rd_mode = 0; stall_pct = 0; rsv_rand = 0;
        clear_log();
        p = '{8'hA5, 8'h5A};
        push_packet(8'h02, 8'h55, 16'hBEEF, 24'h010000, p, 0);
        drain(200);
        chk("maxlen_new_count", new_seen, 1);
        chk("maxlen_len", pkt_len, 24'h010000);
        chk("maxlen_xfer_count", xfer_q.size(), 2);
        do_reset(3);
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        drain(200);
        check_abc("t4", 1);

`ifdef INPKT_CHECKSUM_EN
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        push_packet(8'h02, 8'h09, 16'h4321, 24'd2, p, 0);
        drain(200);
        chk("csum_new_count", new_seen, 2);
        chk("csum_ok_err", {err_version, err_len, err_checksum}, 0);
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 1);
        run(40);
        chk("csum_bad_err", err_checksum, 1);
        do_reset(2);
`endif

        // Length one past the maximum
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'h010001, abc, 0);
        run(20);
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        run(20);
        chk("len_big_err_len", err_len, 1);
        chk("len_big_err_ver", err_version, 0);
        chk("len_big_new_count", new_seen, 0);
        chk("len_big_rd_en", rd_en, 0);
        do_reset(2);

        // Zero length
        clear_log();
        push_packet(8'h02, 8'h07, 16'h1234, 24'd0, abc, 0);
        run(20);
        chk("len_zero_err_len", err_len, 1);
        do_reset(2);

        // Wrong version
        clear_log();
        push_packet(8'h01, 8'h07, 16'h1234, 24'd3, abc, 0);
        push_packet(8'h02, 8'h07, 16'h1234, 24'd3, abc, 0);
        run(30);
        chk("ver_err_version", err_version, 1);
        chk("ver_rd_en", rd_en, 0);
        chk("ver_new_count", new_seen, 0);
        chk("ver_dout_valid", dout_valid, 0);
        do_reset(2);
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
